// File: rtl/axi4_lite_imem_slave.sv
// AXI4-Lite slave fronting a single-port word memory with byte strobes.
// One transaction in flight; reads take two cycles from AR handshake to RVALID.
module axi4_lite_imem_slave #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int          AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD_MEM, RD_RESP, WR_RESP} state_t;

    state_t        state;
    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] rd_idx;
    logic          rd_ok;

    logic [31:0]   rd_off;
    logic [31:0]   wr_off;
    logic          rd_in_range;
    logic          wr_in_range;
    logic [AW-1:0] wr_idx;
    logic          ar_hs;
    logic          wr_hs;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign rd_off      = S_AXI_ARADDR - BASE_ADDR;
    assign wr_off      = S_AXI_AWADDR - BASE_ADDR;
    assign rd_in_range = {1'b0, rd_off} < SPAN;
    assign wr_in_range = {1'b0, wr_off} < SPAN;
    assign wr_idx      = wr_off[AW+1:2];

    // NOTE: the ready signals are combinational so AW and W can handshake in
    // the cycle both valids appear; they are forced low while rst is high.
    assign S_AXI_ARREADY = !rst && (state == IDLE);
    assign S_AXI_AWREADY = !rst && (state == IDLE) && S_AXI_AWVALID && S_AXI_WVALID
                           && !S_AXI_ARVALID;
    assign S_AXI_WREADY  = S_AXI_AWREADY;

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign wr_hs = S_AXI_AWREADY;

    logic unused_bits;
    assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           rd_off[1:0], rd_off[31:AW+2], wr_off[1:0], wr_off[31:AW+2]};

    // NOTE: the memory array has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (wr_hs && wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) mem[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_idx       <= '0;
            rd_ok        <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_BVALID <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ar_hs) begin
                        rd_idx <= rd_off[AW+1:2];
                        rd_ok  <= rd_in_range;
                        state  <= RD_MEM;
                    end else if (wr_hs) begin
                        S_AXI_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        S_AXI_BVALID <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                RD_MEM: begin
                    S_AXI_RDATA  <= rd_ok ? mem[rd_idx] : '0;
                    S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    S_AXI_RVALID <= 1'b1;
                    state        <= RD_RESP;
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_imem_slave.sv
// Directed plus randomized checks of axi4_lite_imem_slave against an
// array-based model of the addressable words.
module tb_axi4_lite_imem_slave;

    localparam int          MW   = 256;
    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [MW];

    always #5 clk = ~clk;

    axi4_lite_imem_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'(MW * 4);
    endfunction

    function automatic int widx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off >> 2);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        return in_rng(addr) ? model_mem[widx(addr)] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return in_rng(addr) ? 2'b00 : 2'b10;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int bstall);
        int n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWPROT  = 3'($urandom);
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        #1;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 10) begin
            tick();
            #1;
            n++;
        end
        check("wr_accept", 32'(S_AXI_AWREADY && S_AXI_WREADY), 32'd1);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (in_rng(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[widx(addr)][8*b +: 8] = data[8*b +: 8];
        end
        check("bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("bresp", 32'(S_AXI_BRESP), 32'(exp_resp(addr)));
        for (int i = 0; i < bstall; i++) begin
            tick();
            check("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            check("bresp_hold", 32'(S_AXI_BRESP), 32'(exp_resp(addr)));
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rstall);
        int n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARPROT  = 3'($urandom);
        S_AXI_ARVALID = 1'b1;
        #1;
        while (!S_AXI_ARREADY && n < 10) begin
            tick();
            #1;
            n++;
        end
        check("rd_accept", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        check("rvalid_early", 32'(S_AXI_RVALID), 32'd0);
        tick();
        check("rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("rdata", S_AXI_RDATA, exp_rdata(addr));
        check("rresp", 32'(S_AXI_RRESP), 32'(exp_resp(addr)));
        for (int i = 0; i < rstall; i++) begin
            tick();
            check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            check("rdata_hold", S_AXI_RDATA, exp_rdata(addr));
            check("rresp_hold", 32'(S_AXI_RRESP), 32'(exp_resp(addr)));
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check("rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARPROT = '0;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) tick();
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        check("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_arready", 32'(S_AXI_ARREADY), 32'd1);
        tick();

        // Basic write then read back.
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        do_read(BASE + 32'h10, 0);

        // Byte-strobe merge, then an all-zero strobe that must change nothing.
        do_write(BASE + 32'h8, 32'h1122_3344, 4'hF, 1);
        do_write(BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, 0);
        do_read(BASE + 32'h8, 0);
        do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0);
        do_read(BASE + 32'hB, 0);

        // Range boundaries: one past the end, below the base, and the last word.
        do_write(BASE, 32'h0BAD_F00D, 4'hF, 0);
        do_write(BASE + 32'(MW * 4), 32'h1234_5678, 4'hF, 2);
        do_read(BASE + 32'(MW * 4), 0);
        do_read(BASE, 0);
        do_write(BASE - 32'h4, 32'h5555_AAAA, 4'hF, 0);
        do_read(BASE - 32'h4, 0);
        do_write(BASE + 32'(MW * 4) - 32'h4, 32'hC0DE_0001, 4'hF, 0);
        do_read(BASE + 32'(MW * 4) - 32'h4, 0);

        // RREADY withheld for five cycles.
        do_read(BASE + 32'h10, 5);

        // Read and write requested in the same IDLE cycle: read wins.
        S_AXI_ARADDR  = BASE + 32'h10;
        S_AXI_AWADDR  = BASE + 32'h14;
        S_AXI_WDATA   = 32'hCAFE_F00D;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        #1;
        check("col_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("col_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("col_wready", 32'(S_AXI_WREADY), 32'd0);
        tick();
        S_AXI_ARVALID = 1'b0;
        #1;
        check("col_awready_rdmem", 32'(S_AXI_AWREADY), 32'd0);
        check("col_rvalid_early", 32'(S_AXI_RVALID), 32'd0);
        tick();
        check("col_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("col_rdata", S_AXI_RDATA, exp_rdata(BASE + 32'h10));
        check("col_awready_rdresp", 32'(S_AXI_AWREADY), 32'd0);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        #1;
        check("col_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
        check("col_wr_accept", 32'(S_AXI_AWREADY && S_AXI_WREADY), 32'd1);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        model_mem[widx(BASE + 32'h14)] = 32'hCAFE_F00D;
        check("col_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("col_bresp", 32'(S_AXI_BRESP), 32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("col_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
        do_read(BASE + 32'h14, 0);

        // Reset while a read response is pending.
        S_AXI_ARADDR  = BASE + 32'h10;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        tick();
        check("rr_rvalid_before", 32'(S_AXI_RVALID), 32'd1);
        rst = 1'b1;
        tick();
        check("rr_rvalid_cleared", 32'(S_AXI_RVALID), 32'd0);
        check("rr_arready_in_rst", 32'(S_AXI_ARREADY), 32'd0);
        rst = 1'b0;
        #1;
        check("rr_arready_after", 32'(S_AXI_ARREADY), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr_no_stale", 32'(S_AXI_RVALID), 32'd0);
        end
        do_read(BASE + 32'h10, 0);

        // Randomized traffic over a pre-initialized pool of words.
        for (int w = 0; w < 16; w++) do_write(BASE + 32'(w * 4), $urandom, 4'hF, 0);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: a = BASE + 32'(MW * 4) + 32'(4 * $urandom_range(0, 63));
                1: a = BASE - 32'(4 * $urandom_range(1, 64));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
